// File: rtl/tl_mon_pkg.sv
// Shared types for the lamp-side traffic-light safety monitor.
package tl_mon_pkg;

   typedef enum logic [1:0] {
      RED     = 2'd0,
      YELLOW  = 2'd1,
      GREEN   = 2'd2,
      INVALID = 2'd3
   } colour_t;

   typedef enum logic [2:0] {
      FC_NONE         = 3'd0,
      FC_CONFLICT     = 3'd1,
      FC_INVALID      = 3'd2,
      FC_SKIP_YELLOW  = 3'd3,
      FC_SHORT_YELLOW = 3'd4,
      FC_BAD_SEQ      = 3'd5
   } fault_code_t;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } mon_state_t;

   localparam int LAMP_R = 0;
   localparam int LAMP_Y = 1;
   localparam int LAMP_G = 2;

   // Exactly one lit lamp names the colour; anything else is INVALID.
   function automatic colour_t decode_lamps(input logic [2:0] lamps);
      colour_t c;
      case (lamps)
         3'b001:  c = RED;
         3'b010:  c = YELLOW;
         3'b100:  c = GREEN;
         default: c = INVALID;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/lamp_channel_check.sv
// Per-light decode, colour history, yellow duration counter and transition flags.
module lamp_channel_check
   import tl_mon_pkg::*;
#(
   parameter int MIN_YELLOW = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_i,
   input  logic [2:0] lamp_i,
   output logic [1:0] colour_o,
   output logic       invalid_o,
   output logic       skip_o,
   output logic       short_o,
   output logic       bad_seq_o
);

   localparam logic [7:0] MIN_Y8 = 8'(MIN_YELLOW);

   colour_t    cur_s;
   colour_t    prev_q, prev_d;
   logic [7:0] ycnt_q, ycnt_d;

   // History and yellow-duration next state; the entry tick into YELLOW counts as 1.
   always_comb begin
      cur_s  = decode_lamps(lamp_i);
      prev_d = prev_q;
      ycnt_d = ycnt_q;
      if (tick_i) begin
         prev_d = cur_s;
         if (cur_s == YELLOW) begin
            if (prev_q != YELLOW) begin
               ycnt_d = 8'd1;
            end else if (ycnt_q != 8'hFF) begin
               ycnt_d = ycnt_q + 8'd1;
            end else begin
               ycnt_d = ycnt_q;
            end
         end else begin
            ycnt_d = 8'd0;
         end
      end else begin
         prev_d = prev_q;
         ycnt_d = ycnt_q;
      end
   end

   // History registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q <= RED;
         ycnt_q <= 8'd0;
      end else begin
         prev_q <= prev_d;
         ycnt_q <= ycnt_d;
      end
   end

   assign colour_o  = cur_s;
   assign invalid_o = (cur_s == INVALID);
   assign skip_o    = (prev_q == GREEN) && (cur_s == RED);
   assign short_o   = (prev_q == YELLOW) && (cur_s == RED) && (ycnt_q < MIN_Y8);
   assign bad_seq_o = ((prev_q == RED) && (cur_s == YELLOW)) ||
                      ((prev_q == YELLOW) && (cur_s == GREEN));

endmodule

// File: rtl/lamp_conflict_monitor.sv
// Lamp-side safety monitor: pairwise conflicts, priority encode, fault latch FSM.
// Optional fault history FIFO enabled by defining FAULT_LOG_EN.
module lamp_conflict_monitor
   import tl_mon_pkg::*;
#(
   parameter int N_LIGHTS     = 4,
   parameter int MIN_YELLOW   = 3,
   parameter int SETTLE_TICKS = 2,
   parameter logic [N_LIGHTS*N_LIGHTS-1:0] PERMIT = {(N_LIGHTS*N_LIGHTS){1'b0}}
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic [N_LIGHTS-1:0][2:0] leds,
   input  logic                     fault_clr,
   output logic                     fault,
   output logic [2:0]               fault_code,
   output logic [1:0]               fault_light,
   output logic                     force_flash,
   input  logic                     log_rd,
   output logic                     log_valid,
   output logic [4:0]               log_data
);

   localparam logic [7:0] SETTLE_T = 8'(SETTLE_TICKS);

   logic [N_LIGHTS-1:0] nonred_s, all_red_v;
   logic [N_LIGHTS-1:0] cls_v [4];
   logic                all_red_s;

   for (genvar g = 0; g < N_LIGHTS; g++) begin : g_chan
      logic [1:0] colour_s;
      lamp_channel_check #(.MIN_YELLOW(MIN_YELLOW)) u_chan (
         .clk       (clk),
         .rst       (rst),
         .tick_i    (tick),
         .lamp_i    (leds[g]),
         .colour_o  (colour_s),
         .invalid_o (cls_v[0][g]),
         .skip_o    (cls_v[1][g]),
         .short_o   (cls_v[2][g]),
         .bad_seq_o (cls_v[3][g])
      );
      assign nonred_s[g]  = (colour_t'(colour_s) != RED);
      assign all_red_v[g] = ~nonred_s[g];
   end

   assign all_red_s = &all_red_v;

   fault_code_t viol_code_s;
   logic [1:0]  viol_light_s;

   // Violation priority: conflict, then per-light classes in order, lowest index first.
   always_comb begin
      viol_code_s  = FC_NONE;
      viol_light_s = 2'd0;
      for (int i = 0; i < N_LIGHTS; i++) begin
         for (int j = i + 1; j < N_LIGHTS; j++) begin
            if ((viol_code_s == FC_NONE) && nonred_s[i] && nonred_s[j] &&
                (!PERMIT[i*N_LIGHTS+j] || !PERMIT[j*N_LIGHTS+i])) begin
               viol_code_s  = FC_CONFLICT;
               viol_light_s = 2'(i);
            end else begin
               viol_code_s  = viol_code_s;
            end
         end
      end
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < N_LIGHTS; i++) begin
            if ((viol_code_s == FC_NONE) && cls_v[c][i]) begin
               viol_code_s  = fault_code_t'(3'(c + 2));
               viol_light_s = 2'(i);
            end else begin
               viol_code_s  = viol_code_s;
            end
         end
      end
   end

   mon_state_t state_q, state_d;
   logic [7:0] settle_q, settle_d;
   logic       fault_q, fault_d, flash_q, flash_d;
   logic [2:0] code_q, code_d;
   logic [1:0] light_q, light_d;
   logic       push_s;

   // FSM next state and registered-output next values; nothing moves without tick.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      fault_d  = fault_q;
      flash_d  = flash_q;
      code_d   = code_q;
      light_d  = light_q;
      push_s   = 1'b0;
      if (tick) begin
         case (state_q)
            ST_INIT: begin
               fault_d = 1'b0;
               flash_d = 1'b1;
               if (!all_red_s) begin
                  settle_d = 8'd0;
               end else if ((settle_q + 8'd1) >= SETTLE_T) begin
                  state_d  = ST_RUN;
                  flash_d  = 1'b0;
                  settle_d = 8'd0;
               end else begin
                  settle_d = settle_q + 8'd1;
               end
            end
            ST_RUN: begin
               flash_d = 1'b0;
               if (viol_code_s != FC_NONE) begin
                  state_d = ST_FAULT;
                  fault_d = 1'b1;
                  flash_d = 1'b1;
                  code_d  = viol_code_s;
                  light_d = viol_light_s;
                  push_s  = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_FAULT: begin
               if (fault_clr && all_red_s) begin
                  state_d  = ST_INIT;
                  fault_d  = 1'b0;
                  flash_d  = 1'b1;
                  code_d   = 3'd0;
                  light_d  = 2'd0;
                  settle_d = 8'd0;
               end else begin
                  state_d = ST_FAULT;
               end
            end
            default: begin
               state_d  = ST_INIT;
               fault_d  = 1'b0;
               flash_d  = 1'b1;
               code_d   = 3'd0;
               light_d  = 2'd0;
               settle_d = 8'd0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // FSM and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_INIT;
         settle_q <= 8'd0;
         fault_q  <= 1'b0;
         flash_q  <= 1'b1;
         code_q   <= 3'd0;
         light_q  <= 2'd0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         fault_q  <= fault_d;
         flash_q  <= flash_d;
         code_q   <= code_d;
         light_q  <= light_d;
      end
   end

   assign fault       = fault_q;
   assign fault_code  = code_q;
   assign fault_light = light_q;
   assign force_flash = flash_q;

`ifdef FAULT_LOG_EN
   logic [4:0] log_mem_q [4];
   logic [1:0] wr_q, rd_q;
   logic [2:0] cnt_q;
   logic       do_push_s, do_pop_s;

   assign do_push_s = push_s && (cnt_q != 3'd4);
   assign do_pop_s  = log_rd && (cnt_q != 3'd0);

   // Fault log FIFO; a full log keeps its oldest entries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            log_mem_q[k] <= 5'd0;
         end
         wr_q  <= 2'd0;
         rd_q  <= 2'd0;
         cnt_q <= 3'd0;
      end else begin
         if (do_push_s) begin
            log_mem_q[wr_q] <= {code_d, light_d};
            wr_q            <= wr_q + 2'd1;
         end
         if (do_pop_s) begin
            rd_q <= rd_q + 2'd1;
         end
         cnt_q <= cnt_q + {2'd0, do_push_s} - {2'd0, do_pop_s};
      end
   end

   assign log_valid = (cnt_q != 3'd0);
   assign log_data  = log_valid ? log_mem_q[rd_q] : 5'd0;
`else
   logic unused_log_rd;
   assign unused_log_rd = log_rd;
   assign log_valid     = 1'b0;
   assign log_data      = 5'd0;
`endif

endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// Directed bench for lamp_conflict_monitor with hand-computed expectations.
module tb_lamp_conflict_monitor;

   localparam logic [2:0] R = 3'b001;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b100;
   localparam logic [11:0] ALLR = {R, R, R, R};

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             tick = 1'b0;
   logic [3:0][2:0]  leds = ALLR;
   logic             fault_clr = 1'b0;
   logic             fault;
   logic [2:0]       fault_code;
   logic [1:0]       fault_light;
   logic             force_flash;
   logic             log_rd = 1'b0;
   logic             log_valid;
   logic [4:0]       log_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lamp_conflict_monitor dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .leds        (leds),
      .fault_clr   (fault_clr),
      .fault       (fault),
      .fault_code  (fault_code),
      .fault_light (fault_light),
      .force_flash (force_flash),
      .log_rd      (log_rd),
      .log_valid   (log_valid),
      .log_data    (log_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply one lamp pattern with tick=1 for a single clock, then sample.
   task automatic step(input logic [11:0] l, input logic clr);
      @(negedge clk);
      leds      = l;
      fault_clr = clr;
      tick      = 1'b1;
      @(posedge clk);
      #1;
      tick      = 1'b0;
      fault_clr = 1'b0;
   endtask

   task automatic check_fault(input string tag, input logic [2:0] code, input logic [1:0] light);
      check({tag, "_fault"}, fault, 1'b1);
      check({tag, "_code"}, fault_code, code);
      check({tag, "_light"}, fault_light, light);
      check({tag, "_flash"}, force_flash, 1'b1);
   endtask

   task automatic clear_and_settle(input string tag);
      step(ALLR, 1'b1);
      check({tag, "_clr_fault"}, fault, 1'b0);
      check({tag, "_clr_code"}, fault_code, 3'd0);
      check({tag, "_clr_flash"}, force_flash, 1'b1);
      step(ALLR, 1'b0);
      check({tag, "_settle1"}, force_flash, 1'b1);
      step(ALLR, 1'b0);
      check({tag, "_settle2"}, force_flash, 1'b0);
   endtask

   task automatic pop();
      @(negedge clk);
      log_rd = 1'b1;
      @(posedge clk);
      #1;
      log_rd = 1'b0;
   endtask

   initial begin
      #12;
      check("rst_fault", fault, 1'b0);
      check("rst_code", fault_code, 3'd0);
      check("rst_light", fault_light, 2'd0);
      check("rst_flash", force_flash, 1'b1);
      check("rst_log_valid", log_valid, 1'b0);
      check("rst_log_data", log_data, 5'd0);
      @(negedge clk);
      rst = 1'b0;

      // Settling, with a GREEN restarting the count
      step(ALLR, 1'b0);
      check("settle_a", force_flash, 1'b1);
      step({R, R, R, G}, 1'b0);
      check("settle_green", force_flash, 1'b1);
      step(ALLR, 1'b0);
      check("settle_b", force_flash, 1'b1);
      step(ALLR, 1'b0);
      check("settle_done", force_flash, 1'b0);
      check("settle_fault", fault, 1'b0);

      // tick=0 must hold state even with a conflicting pattern on the bus
      @(negedge clk);
      leds = {R, G, R, G};
      @(posedge clk);
      #1;
      check("notick_hold", fault, 1'b0);

      // Legal cycle on light0
      for (int k = 0; k < 5; k++) begin
         step({R, R, R, G}, 1'b0);
         check("legal_green", fault, 1'b0);
      end
      for (int k = 0; k < 3; k++) begin
         step({R, R, R, Y}, 1'b0);
         check("legal_yellow", fault, 1'b0);
      end
      step(ALLR, 1'b0);
      check("legal_red", fault, 1'b0);
      check("legal_flash", force_flash, 1'b0);

      // Fault 1: conflict between lights 1 and 3
      step({G, R, G, R}, 1'b0);
      check_fault("conflict", 3'd1, 2'd1);
      clear_and_settle("c1");

      // Fault 2: skipped yellow on light2
      step({R, G, R, R}, 1'b0);
      check("skip_pre", fault, 1'b0);
      step(ALLR, 1'b0);
      check_fault("skip", 3'd3, 2'd2);
      clear_and_settle("c2");

      // Fault 3: yellow held only 2 ticks on light1
      step({R, R, G, R}, 1'b0);
      step({R, R, Y, R}, 1'b0);
      step({R, R, Y, R}, 1'b0);
      check("short_pre", fault, 1'b0);
      step(ALLR, 1'b0);
      check_fault("short", 3'd4, 2'd1);
      clear_and_settle("c3");

      // Fault 4: invalid light0 outranks skip on light2
      step({R, G, R, R}, 1'b0);
      step({R, R, R, 3'b011}, 1'b0);
      check_fault("prio", 3'd2, 2'd0);
      step({R, G, R, R}, 1'b1);
      check("clr_ignored_fault", fault, 1'b1);
      check("clr_ignored_code", fault_code, 3'd2);
      clear_and_settle("c4");

      // Fault 5: RED straight to YELLOW on light3
      step({Y, R, R, R}, 1'b0);
      check_fault("badseq", 3'd5, 2'd3);
      clear_and_settle("c5");

`ifdef FAULT_LOG_EN
      check("log_v0", log_valid, 1'b1);
      check("log_d0", log_data, 5'h05);
      pop();
      check("log_d1", log_data, 5'h0E);
      pop();
      check("log_d2", log_data, 5'h11);
      pop();
      check("log_d3", log_data, 5'h08);
      pop();
      check("log_empty", log_valid, 1'b0);
      pop();
      check("log_extra_rd", log_valid, 1'b0);
      check("log_extra_data", log_data, 5'd0);
`else
      pop();
      check("nolog_valid", log_valid, 1'b0);
      check("nolog_data", log_data, 5'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
